divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter XW, default 8, dividend and quotient width.
REQ-002 SHALL have parameter YW, default 4, divisor and remainder width; XW >= YW >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a division.
REQ-006 SHALL have port x  input  XW  unsigned dividend, sampled only when start is accepted.
REQ-007 SHALL have port y  input  YW  unsigned divisor, sampled only when start is accepted.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse; q, r and dbz are valid.
REQ-010 SHALL have port q  output  XW  quotient.
REQ-011 SHALL have port r  output  YW  remainder.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-013 SHALL implement an FSM with the states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE; start in RUN or DONE is ignored with no effect on the current operation.
REQ-015 On accept edge E0 with y != 0, SHALL latch x and y, clear the partial remainder, clear dbz and enter RUN.
REQ-016 SHALL, in RUN, perform one restoring step per cycle, MSB of the dividend first:
  - shift the next dividend bit into the partial remainder (YW+1 bits internally);
  - subtract the divisor if the remainder >= divisor;
  - shift the resulting quotient bit in.
REQ-017 SHALL stay in RUN for exactly XW cycles (edges E1..E_XW) and enter DONE at edge E_XW.
REQ-018 SHALL assert done for exactly one cycle while in DONE, then return to IDLE on the next edge.
REQ-019 SHALL present final q and r while done is high, and hold them and dbz stable until the next accepted start.
REQ-020 SHALL satisfy q*y + r == x and r < y for every y != 0.
REQ-021 SHALL assert busy exactly while in RUN or DONE; busy is low in IDLE.
REQ-022 On accept with y == 0, SHALL go directly to DONE at E0 and set dbz=1, q=all ones, r=0; done pulses in the following cycle.
REQ-023 SHALL allow start to be accepted in the cycle immediately after done (back-to-back operation).
REQ-024 SHALL not depend on changes to x and y after the accept edge.

Reset
REQ-025 SHALL, while rst_n is low, immediately force state=IDLE and busy=0, done=0, q=0, r=0, dbz=0, independent of clk.
REQ-026 SHALL discard any operation in progress when reset asserts mid-operation and produce no done pulse for it.
REQ-027 SHALL, after rst_n deasserts, accept start from the first rising edge of clk.

Verification
REQ-028 SHALL verify x=200, y=7 -> done exactly 9 cycles after accept (XW+1 edges), q=28, r=4, dbz=0.
REQ-029 SHALL verify x=255, y=1 -> q=255, r=0; and x=3, y=9 -> q=0, r=3.
REQ-030 SHALL verify x=100, y=0 -> done 1 cycle after accept, dbz=1, q=8'hFF, r=0.
REQ-031 SHALL verify that start pulsed mid-RUN with x=1, y=1 leaves the result of the first operation unchanged and produces only one done pulse.
REQ-032 SHALL verify that rst_n pulsed low at cycle 4 of RUN -> outputs all 0 immediately, and no done pulse follows.
REQ-033 SHALL verify exhaustively all 256x16 operand pairs back-to-back against a reference model for q, r and dbz.

Source files
------------

// File: rtl/divider.sv
`timescale 1ns/1ps
// divider -- sequential unsigned restoring divider, one quotient bit per clock.
//
// A division is requested with start while the block is idle. The quotient
// (XW bits) and remainder (YW bits) are produced XW cycles later and announced
// by a single-cycle done pulse. A zero divisor completes immediately with dbz
// set, q all ones and r zero. Results and dbz hold until the next accepted start.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   begin a division (honoured only when idle)
//   x      in   XW  unsigned dividend, sampled on accept
//   y      in   YW  unsigned divisor, sampled on accept
//   busy   out  1   division in progress (RUN or DONE)
//   done   out  1   one-cycle pulse, q/r/dbz valid
//   q      out  XW  quotient
//   r      out  YW  remainder
//   dbz    out  1   divide-by-zero flag of the last completed operation
module divider #(
  parameter int XW = 8,
  parameter int YW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] q,
  output logic [YW-1:0] r,
  output logic          dbz
);

  localparam int CW = (XW > 1) ? $clog2(XW) : 1;
  localparam logic [CW-1:0] LAST = CW'(XW - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [YW-1:0] y_q, y_d;
  // q_q doubles as the dividend shift register: each step shifts the top
  // dividend bit out into the remainder and a quotient bit in at the bottom,
  // so after XW steps it holds the full quotient.
  logic [XW-1:0] q_q, q_d;
  logic [YW-1:0] r_q, r_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  // Partial remainder after shifting in the next dividend bit; one bit wider
  // than the divisor because it can temporarily reach 2*y-1.
  logic [YW:0]   rem_sh;
  logic          ge;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    rem_sh  = {r_q, q_q[XW-1]};
    ge      = (rem_sh >= {1'b0, y_q});

    case (state_q)
      IDLE: begin
        if (start) begin
          if (y == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = '0;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            y_d     = y;
            q_d     = x;
            r_d     = '0;
            dbz_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        q_d   = XW'({q_q, ge});
        r_d   = ge ? YW'(rem_sh - {1'b0, y_q}) : rem_sh[YW-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_divider.sv
`timescale 1ns/1ps
// Self-checking bench for divider: arithmetic reference model tracking each
// accepted operation, a per-cycle compare process, and directed literal checks.
module tb_divider;
  localparam int XW = 8;
  localparam int YW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [XW-1:0] x     = '0;
  logic [YW-1:0] y     = '0;
  logic          busy, done, dbz;
  logic [XW-1:0] q;
  logic [YW-1:0] r;

  int n_cmp    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  // Reference model state: accept cycle, cycle of the done pulse, results.
  bit            m_active = 1'b0;
  int            m_acc    = 0;
  int            m_due    = 0;
  logic [XW-1:0] p_q      = '0;
  logic [YW-1:0] p_r      = '0;
  logic          p_dbz    = 1'b0;
  logic          eb, ed;

  divider #(.XW(XW), .YW(YW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: an operation is accepted when start is seen while no operation
  // occupies the cycle; it finishes XW+1 edges later (1 edge for y == 0).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
    end else if (!(m_active && cyc <= m_due) && start) begin
      m_active <= 1'b1;
      m_acc    <= cyc + 1;
      if (y == '0) begin
        m_due <= cyc + 1;
        p_q   <= '1;
        p_r   <= '0;
        p_dbz <= 1'b1;
      end else begin
        m_due <= cyc + 1 + XW;
        p_q   <= XW'(x / y);
        p_r   <= YW'(x % y);
        p_dbz <= 1'b0;
      end
    end
  end

  // Compare process: busy/done every cycle, results whenever they must be stable.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      eb = m_active && (cyc >= m_acc) && (cyc <= m_due);
      ed = m_active && (cyc == m_due);
      check("busy", busy, eb);
      check("done", done, ed);
      if (!m_active) begin
        check("q_idle", q, 0);
        check("r_idle", r, 0);
        check("dbz_idle", dbz, 0);
      end else if (cyc >= m_due) begin
        check("q", q, p_q);
        check("r", r, p_r);
        check("dbz", dbz, p_dbz);
      end
      if (done) done_cnt++;
    end
  end

  // Waits at negedges for done; returns the cycle it was seen, or -1 on timeout.
  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int k = 0; k < 30; k++) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (dcyc < 0) check("done_timeout", done, 1);
  endtask

  // Issue one operation from a negedge; returns edges from accept to done
  // (accept edge counted as 1) and ends in the idle cycle after done.
  task automatic run_op(input logic [XW-1:0] xi, input logic [YW-1:0] yi, output int lat);
    int acc;
    int dcyc;
    start = 1'b1;
    x     = xi;
    y     = yi;
    @(negedge clk);
    acc   = cyc;
    start = 1'b0;
    x     = XW'($urandom);
    y     = YW'($urandom);
    wait_done(dcyc);
    lat = (dcyc < 0) ? -1 : dcyc - acc + 1;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int dc0;
    int dcyc;

    // Asynchronous reset, asserted between clock edges.
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_dbz", dbz, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // First op issued right away: accepted on the first edge after reset.
    run_op(8'd200, 4'd7, lat);
    check("lat_200_7", lat, 9);
    check("q_200_7", q, 28);
    check("r_200_7", r, 4);
    check("dbz_200_7", dbz, 0);

    run_op(8'd255, 4'd1, lat);
    check("q_255_1", q, 255);
    check("r_255_1", r, 0);

    run_op(8'd3, 4'd9, lat);
    check("q_3_9", q, 0);
    check("r_3_9", r, 3);

    run_op(8'd100, 4'd0, lat);
    check("lat_100_0", lat, 1);
    check("dbz_100_0", dbz, 1);
    check("q_100_0", q, 8'hFF);
    check("r_100_0", r, 0);

    // start pulsed mid-RUN must be ignored.
    dc0   = done_cnt;
    start = 1'b1;
    x     = 8'd50;
    y     = 4'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    x     = 8'd1;
    y     = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(dcyc);
    repeat (12) @(negedge clk);
    check("ignore_done_count", done_cnt - dc0, 1);
    check("ignore_q", q, 8);
    check("ignore_r", r, 2);
    check("ignore_busy", busy, 0);

    // Reset asserted during RUN: outputs clear at once and no done follows.
    dc0   = done_cnt;
    start = 1'b1;
    x     = 8'd200;
    y     = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    check("midrst_dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_cnt - dc0, 0);

    // Exhaustive back-to-back sweep.
    for (int xi = 0; xi < 256; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        run_op(XW'(xi), YW'(yi), lat);
        check("lat_sweep", lat, (yi == 0) ? 1 : 9);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
